// File: rtl/uart_brg_sched.sv
// Per-line baud-rate scheduler for an 8-line UART: holds speed/enable per line and
// runs one 16x clock-enable divider per line with glitch-free speed changes.
module uart_brg_sched #(
  parameter int CLKFRQ = 50000000,
  parameter int CLKDIV = 16,
  parameter int CNTW   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lprWR,
  input  logic [2:0] lprLINE,
  input  logic [2:0] lprSPEED,
  input  logic       lprENA,
  output logic       lprACK,
  output logic [7:0] brgCLKEN,
  output logic [7:0] brgPEND
);

  localparam logic [CNTW-1:0] DIV0 = CNTW'(CLKFRQ / CLKDIV / 1200);
  localparam logic [CNTW-1:0] DIV1 = CNTW'(CLKFRQ / CLKDIV / 2400);
  localparam logic [CNTW-1:0] DIV2 = CNTW'(CLKFRQ / CLKDIV / 4800);
  localparam logic [CNTW-1:0] DIV3 = CNTW'(CLKFRQ / CLKDIV / 9600);
  localparam logic [CNTW-1:0] DIV4 = CNTW'(CLKFRQ / CLKDIV / 19200);
  localparam logic [CNTW-1:0] DIV5 = CNTW'(CLKFRQ / CLKDIV / 38400);
  localparam logic [CNTW-1:0] DIV6 = CNTW'(CLKFRQ / CLKDIV / 57600);
  localparam logic [CNTW-1:0] DIV7 = CNTW'(CLKFRQ / CLKDIV / 115200);

  function automatic logic [CNTW-1:0] div_of(input logic [2:0] code);
    logic [CNTW-1:0] d;
    case (code)
      3'd0:    d = DIV0;
      3'd1:    d = DIV1;
      3'd2:    d = DIV2;
      3'd3:    d = DIV3;
      3'd4:    d = DIV4;
      3'd5:    d = DIV5;
      3'd6:    d = DIV6;
      3'd7:    d = DIV7;
      default: d = DIV0;
    endcase
    return d;
  endfunction

  logic [7:0]      ena;
  logic [7:0]      pend;
  logic [7:0]      clken;
  logic [2:0]      spd   [8];
  logic [2:0]      nspd  [8];
  logic [CNTW-1:0] cnt   [8];
  logic [7:0]      wr_hit;
  logic [2:0]      use_spd [8];

  // Decode the targeted line and pick the speed a reload would apply.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      wr_hit[i]  = lprWR && (lprLINE == 3'(i));
      use_spd[i] = pend[i] ? nspd[i] : spd[i];
    end
  end

  // Per-line dividers plus the LPR write path; a disable write overrides the run rule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lprACK <= 1'b0;
      ena    <= 8'h00;
      pend   <= 8'h00;
      clken  <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        spd[i]  <= 3'd0;
        nspd[i] <= 3'd0;
        cnt[i]  <= '0;
      end
    end else begin
      lprACK <= lprWR;
      for (int i = 0; i < 8; i++) begin
        if (wr_hit[i] && !lprENA) begin
          ena[i]   <= 1'b0;
          cnt[i]   <= '0;
          clken[i] <= 1'b0;
          spd[i]   <= lprSPEED;
          pend[i]  <= 1'b0;
        end else begin
          if (ena[i]) begin
            if (cnt[i] == '0) begin
              cnt[i]   <= div_of(use_spd[i]);
              spd[i]   <= use_spd[i];
              pend[i]  <= 1'b0;
              clken[i] <= 1'b1;
            end else begin
              cnt[i]   <= cnt[i] - CNTW'(1);
              clken[i] <= 1'b0;
            end
          end else begin
            cnt[i]   <= '0;
            clken[i] <= 1'b0;
            pend[i]  <= 1'b0;
          end
          // An enable write lands after the run rule, so a same-edge reload keeps the new speed pending.
          if (wr_hit[i]) begin
            ena[i]  <= 1'b1;
            nspd[i] <= lprSPEED;
            pend[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign brgCLKEN = clken;
  assign brgPEND  = pend;

endmodule

// File: tb/tb_uart_brg_sched.sv
// Directed self-checking bench for uart_brg_sched: latency, periods, pending speed
// changes, same-edge write/reload, line disable isolation and asynchronous reset.
module tb_uart_brg_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       lprWR;
  logic [2:0] lprLINE;
  logic [2:0] lprSPEED;
  logic       lprENA;
  logic       lprACK;
  logic [7:0] brgCLKEN;
  logic [7:0] brgPEND;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lastp [8];

  typedef struct {
    logic [2:0] code;
    int         period;
  } vec_t;
  vec_t tbl [8];

  uart_brg_sched dut (
    .clk      (clk),
    .rst      (rst),
    .lprWR    (lprWR),
    .lprLINE  (lprLINE),
    .lprSPEED (lprSPEED),
    .lprENA   (lprENA),
    .lprACK   (lprACK),
    .brgCLKEN (brgCLKEN),
    .brgPEND  (brgPEND)
  );

  always #5 clk = ~clk;

  // Pulse-time monitor sampled on the falling edge, away from the checks.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 8; i++)
      if (brgCLKEN[i]) lastp[i] = cyc;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int line, input int speed, input logic ena);
    lprWR    = 1'b1;
    lprLINE  = 3'(line);
    lprSPEED = 3'(speed);
    lprENA   = ena;
    step();
    lprWR    = 1'b0;
  endtask

  // Steps at least once, then until the line pulses; n = clocks taken.
  task automatic measure(input int line, input int budget, output int n);
    step();
    n = 1;
    while (!brgCLKEN[line] && n < budget) begin
      step();
      n++;
    end
    if (!brgCLKEN[line]) check("pulse_timeout", line, -1);
  endtask

  initial begin
    int n;
    int p2;
    int snap [8];
    for (int i = 0; i < 8; i++) lastp[i] = 0;
    tbl[0] = '{3'd0, 2605}; tbl[1] = '{3'd1, 1303};
    tbl[2] = '{3'd2, 652};  tbl[3] = '{3'd3, 326};
    tbl[4] = '{3'd4, 163};  tbl[5] = '{3'd5, 82};
    tbl[6] = '{3'd6, 55};   tbl[7] = '{3'd7, 28};

    rst = 1'b1; lprWR = 1'b0; lprLINE = 3'd0; lprSPEED = 3'd0; lprENA = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clken", int'(brgCLKEN), 0);
    check("rst_pend", int'(brgPEND), 0);
    check("rst_ack", int'(lprACK), 0);
    rst = 1'b0;
    step();

    // Line 0 at code 7: ack, latency and period.
    wr(0, 7, 1'b1);
    check("l0_ack", int'(lprACK), 1);
    check("l0_pend_set", int'(brgPEND), 1);
    check("l0_no_early_pulse", int'(brgCLKEN), 0);
    step();
    check("l0_first_pulse", int'(brgCLKEN), 1);
    check("l0_ack_drop", int'(lprACK), 0);
    check("l0_pend_clear", int'(brgPEND), 0);
    measure(0, 100, n);
    check("l0_period", n, 28);
    step();
    check("l0_pulse_width", int'(brgCLKEN[0]), 0);

    // Line 3: speed change mid-count stays pending until the next reload.
    wr(3, 7, 1'b1);
    measure(3, 100, n);
    check("l3_latency", n, 1);
    repeat (10) step();
    wr(3, 6, 1'b1);
    check("l3_pend_mid", int'(brgPEND[3]), 1);
    measure(3, 100, n);
    check("l3_old_interval", n + 11, 28);
    check("l3_pend_applied", int'(brgPEND[3]), 0);
    measure(3, 100, n);
    check("l3_new_period", n, 55);

    // Line 5: write lands on the reload edge.
    wr(5, 7, 1'b1);
    measure(5, 100, n);
    repeat (27) step();
    wr(5, 6, 1'b1);
    check("l5_reload_pulse", int'(brgCLKEN[5]), 1);
    check("l5_pend_kept", int'(brgPEND[5]), 1);
    measure(5, 100, n);
    check("l5_old_speed", n, 28);
    check("l5_pend_applied", int'(brgPEND[5]), 0);
    measure(5, 100, n);
    check("l5_new_period", n, 55);

    // All lines at codes 0..7, back-to-back writes.
    for (int i = 0; i < 8; i++) begin
      wr(i, int'(tbl[i].code), 1'b1);
      check("all_ack", int'(lprACK), 1);
    end
    for (int i = 0; i < 8; i++) begin
      measure(i, 6000, n);
      measure(i, 6000, n);
      check($sformatf("period_l%0d", i), n, tbl[i].period);
    end

    // Disable line 2; the other lines keep phase.
    for (int i = 0; i < 8; i++) snap[i] = lastp[i];
    wr(2, 0, 1'b0);
    check("l2_off_now", int'(brgCLKEN[2]), 0);
    p2 = 0;
    for (int k = 0; k < 2700; k++) begin
      step();
      if (brgCLKEN[2]) p2++;
    end
    check("l2_no_pulses", p2, 0);
    for (int i = 0; i < 8; i++) begin
      if (i != 2)
        check($sformatf("phase_l%0d", i),
              int'(lastp[i] > snap[i] && ((lastp[i] - snap[i]) % tbl[i].period) == 0), 1);
    end

    // Asynchronous reset while a pulse is high.
    n = 0;
    while (brgCLKEN == 8'h00 && n < 100) begin
      step();
      n++;
    end
    check("pre_rst_pulse_seen", int'(brgCLKEN != 8'h00), 1);
    rst = 1'b1;
    #1;
    check("async_rst_clken", int'(brgCLKEN), 0);
    check("async_rst_pend", int'(brgPEND), 0);
    #3;
    rst = 1'b0;
    p2 = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (brgCLKEN != 8'h00) p2++;
    end
    check("post_rst_quiet", p2, 0);

    // Asynchronous reset while ack and pend are high.
    wr(1, 3, 1'b1);
    check("pre_rst_ack", int'(lprACK), 1);
    check("pre_rst_pend", int'(brgPEND), 2);
    rst = 1'b1;
    #1;
    check("async_rst_ack", int'(lprACK), 0);
    check("async_rst_pend2", int'(brgPEND), 0);
    #2;
    rst = 1'b0;
    p2 = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (brgCLKEN != 8'h00) p2++;
    end
    check("post_rst2_quiet", p2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
